// File: rtl/demux_1_to_2_pkg.sv
// Shared select encodings for demux leaves and trees built from them.
// A tree decodes one select bit per level with the same encoding.
package demux_1_to_2_pkg;

    localparam logic SEL_Y0 = 1'b0;
    localparam logic SEL_Y1 = 1'b1;

    // True when the select routes data to the given leg.
    function automatic logic sel_hits(input logic sel, input logic leg);
        return sel == leg;
    endfunction

endpackage

// File: rtl/demux_1_to_2.sv
// 1-to-2 demultiplexer with registered outputs and synchronous reset.
// Each edge loads only that cycle's select/data; the idle leg is forced to zero.
module demux_1_to_2
    import demux_1_to_2_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s,
    input  logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1
);

    logic [WIDTH-1:0] y0_d;
    logic [WIDTH-1:0] y1_d;
    logic [WIDTH-1:0] y0_q;
    logic [WIDTH-1:0] y1_q;

    // Two-way decode: both legs default to zero so no old data can be held.
    always_comb begin
        y0_d = '0;
        y1_d = '0;
        if (sel_hits(s, SEL_Y1)) begin
            y1_d = i;
        end else begin
            y0_d = i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y0_q <= '0;
            y1_q <= '0;
        end else begin
            y0_q <= y0_d;
            y1_q <= y1_d;
        end
    end

    assign y0 = y0_q;
    assign y1 = y1_q;

endmodule

// File: tb/tb_demux_1_to_2.sv
// Directed bench for demux_1_to_2: 1-bit vector table plus latency and 8-bit sequences.
module tb_demux_1_to_2;

    logic       clk;
    logic       rst;
    logic       s1;
    logic [0:0] i1;
    logic [0:0] y0_1;
    logic [0:0] y1_1;
    logic       s8;
    logic [7:0] i8;
    logic [7:0] y0_8;
    logic [7:0] y1_8;

    int n_checks;
    int n_fail;

    demux_1_to_2 #(.WIDTH(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .s   (s1),
        .i   (i1),
        .y0  (y0_1),
        .y1  (y1_1)
    );

    demux_1_to_2 #(.WIDTH(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .s   (s8),
        .i   (i8),
        .y0  (y0_8),
        .y1  (y1_8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic s;
        logic i;
        logic exp_y0;
        logic exp_y1;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        s1  = 1'b1;
        i1  = 1'b1;
        s8  = 1'b0;
        i8  = 8'h00;

        // reset with s=1,i=1, then release
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        // exhaustive sweep
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        // toggle s with i=1
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        // reset mid-stream with s=0,i=1
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            rst = vecs[k].rst;
            s1  = vecs[k].s;
            i1  = vecs[k].i;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d y0", k), {7'd0, y0_1}, {7'd0, vecs[k].exp_y0});
            check($sformatf("vec%0d y1", k), {7'd0, y1_1}, {7'd0, vecs[k].exp_y1});
            check($sformatf("vec%0d w8 idle y0", k), y0_8, 8'h00);
            check($sformatf("vec%0d w8 idle y1", k), y1_8, 8'h00);
        end

        // latency: inputs changed between edges must not reach the outputs
        @(negedge clk);
        rst = 1'b0;
        s1  = 1'b0;
        i1  = 1'b1;
        @(posedge clk);
        #1;
        check("lat base y0", {7'd0, y0_1}, 8'h01);
        check("lat base y1", {7'd0, y1_1}, 8'h00);
        #2;
        s1 = 1'b1;
        #2;
        check("lat hold y0", {7'd0, y0_1}, 8'h01);
        check("lat hold y1", {7'd0, y1_1}, 8'h00);
        i1 = 1'b0;
        #2;
        check("lat hold2 y0", {7'd0, y0_1}, 8'h01);
        i1 = 1'b1;
        @(posedge clk);
        #1;
        check("lat edge y0", {7'd0, y0_1}, 8'h00);
        check("lat edge y1", {7'd0, y1_1}, 8'h01);

        // 8-bit routing
        @(negedge clk);
        s8 = 1'b1;
        i8 = 8'hA5;
        @(posedge clk);
        #1;
        check("w8 s1 y1", y1_8, 8'hA5);
        check("w8 s1 y0", y0_8, 8'h00);
        @(negedge clk);
        s8 = 1'b0;
        @(posedge clk);
        #1;
        check("w8 s0 y0", y0_8, 8'hA5);
        check("w8 s0 y1", y1_8, 8'h00);
        @(negedge clk);
        s8 = 1'b1;
        i8 = 8'h3C;
        @(posedge clk);
        #1;
        check("w8 3c y1", y1_8, 8'h3C);
        check("w8 3c y0", y0_8, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("w8 rst y0", y0_8, 8'h00);
        check("w8 rst y1", y1_8, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("w8 post rst y1", y1_8, 8'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // both outputs must never be non-zero together
    always @(negedge clk) begin
        if (!rst && n_checks > 0) begin
            check("w1 one-hot", {7'd0, y0_1 & y1_1}, 8'h00);
            check("w8 one-hot", y0_8 & y1_8, 8'h00);
        end
    end

endmodule
